// File: rtl/channel_rendezvous_pkg.sv
// Shared constants for the channel rendezvous block: channel record layout,
// RAM access modes and FSM state encodings.
package channel_rendezvous_pkg;

  localparam int CHANNEL_OCCUPIED_BIT   = 15;
  localparam int CHANNEL_SENDER_BIT     = 14;
  localparam int CHANNEL_MESSAGE_OFFSET = 1;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ_HDR  = 3'd1,
    ST_PARK_HDR  = 3'd2,
    ST_PARK_MSG  = 3'd3,
    ST_CLEAR_HDR = 3'd4,
    ST_READ_MSG  = 3'd5,
    ST_DELIVER   = 3'd6,
    ST_DONE      = 3'd7
  } rv_state_t;

endpackage

// File: rtl/channel_rendezvous.sv
// Memory side of a channel SEND/RECEIVE: parks the caller on an empty channel or
// pairs it with the waiting partner and hands the value to the delivery stage.
module channel_rendezvous
  import channel_rendezvous_pkg::*;
#(
  parameter int addrBits = 8,
  parameter int dataBits = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                isSend,
  input  logic [addrBits-1:0] callerProcess,
  input  logic [dataBits-1:0] value,
  input  logic [addrBits-1:0] channelAddr,
  output logic                busy,
  output logic                done,
  output logic                callerBlocks,
  output logic                wakeValid,
  output logic [addrBits-1:0] wakeProcess,
  output logic                error,
  output logic                memoryCellReadWriteMode,
  output logic [addrBits-1:0] memoryCellAddress,
  output logic [dataBits-1:0] memoryCellDataIn,
  input  logic [dataBits-1:0] memoryCellDataOut,
  output logic                deliveryStart,
  output logic [addrBits-1:0] deliveryTarget,
  output logic [dataBits-1:0] deliveryMessage,
  input  logic                deliveryFinished
);

  rv_state_t           r_state;
  logic                r_tick;
  logic                r_isSend;
  logic [addrBits-1:0] r_caller;
  logic [dataBits-1:0] r_value;
  logic [addrBits-1:0] r_chanAddr;
  logic [addrBits-1:0] r_waiter;

  logic [dataBits-1:0] w_parkHeader;
  logic [addrBits-1:0] w_msgAddr;

  assign w_parkHeader = {1'b1, r_isSend, {(dataBits-2-addrBits){1'b0}}, r_caller};
  assign w_msgAddr    = r_chanAddr + addrBits'(CHANNEL_MESSAGE_OFFSET);

  // Rendezvous FSM; each RAM state spends two cycles, advancing on tick=1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state                 <= ST_IDLE;
      r_tick                  <= 1'b0;
      r_isSend                <= 1'b0;
      r_caller                <= '0;
      r_value                 <= '0;
      r_chanAddr              <= '0;
      r_waiter                <= '0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      callerBlocks            <= 1'b0;
      wakeValid               <= 1'b0;
      wakeProcess             <= '0;
      error                   <= 1'b0;
      memoryCellReadWriteMode <= RAM_READ;
      memoryCellAddress       <= '0;
      memoryCellDataIn        <= '0;
      deliveryStart           <= 1'b0;
      deliveryTarget          <= '0;
      deliveryMessage         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tick <= 1'b0;
          if (start) begin
            r_isSend                <= isSend;
            r_caller                <= callerProcess;
            r_value                 <= value;
            r_chanAddr              <= channelAddr;
            busy                    <= 1'b1;
            memoryCellAddress       <= channelAddr;
            memoryCellReadWriteMode <= RAM_READ;
            r_state                 <= ST_READ_HDR;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_READ_HDR: begin
          if (!r_tick) begin
            r_tick <= 1'b1;
          end else begin
            r_tick   <= 1'b0;
            r_waiter <= memoryCellDataOut[addrBits-1:0];
            if (!memoryCellDataOut[CHANNEL_OCCUPIED_BIT]) begin
              memoryCellReadWriteMode <= RAM_WRITE;
              memoryCellDataIn        <= w_parkHeader;
              r_state                 <= ST_PARK_HDR;
            end else if (memoryCellDataOut[CHANNEL_SENDER_BIT] != r_isSend) begin
              memoryCellReadWriteMode <= RAM_WRITE;
              memoryCellDataIn        <= '0;
              r_state                 <= ST_CLEAR_HDR;
            end else begin
              done    <= 1'b1;
              error   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_PARK_HDR: begin
          if (!r_tick) begin
            r_tick <= 1'b1;
          end else begin
            r_tick <= 1'b0;
            if (r_isSend) begin
              memoryCellAddress <= w_msgAddr;
              memoryCellDataIn  <= r_value;
              r_state           <= ST_PARK_MSG;
            end else begin
              memoryCellReadWriteMode <= RAM_READ;
              done                    <= 1'b1;
              callerBlocks            <= 1'b1;
              r_state                 <= ST_DONE;
            end
          end
        end

        ST_PARK_MSG: begin
          if (!r_tick) begin
            r_tick <= 1'b1;
          end else begin
            r_tick                  <= 1'b0;
            memoryCellReadWriteMode <= RAM_READ;
            done                    <= 1'b1;
            callerBlocks            <= 1'b1;
            r_state                 <= ST_DONE;
          end
        end

        ST_CLEAR_HDR: begin
          if (!r_tick) begin
            r_tick <= 1'b1;
          end else begin
            r_tick                  <= 1'b0;
            memoryCellReadWriteMode <= RAM_READ;
            if (r_isSend) begin
              deliveryStart   <= 1'b1;
              deliveryTarget  <= r_waiter;
              deliveryMessage <= r_value;
              r_state         <= ST_DELIVER;
            end else begin
              memoryCellAddress <= w_msgAddr;
              r_state           <= ST_READ_MSG;
            end
          end
        end

        ST_READ_MSG: begin
          if (!r_tick) begin
            r_tick <= 1'b1;
          end else begin
            r_tick          <= 1'b0;
            deliveryStart   <= 1'b1;
            deliveryTarget  <= r_caller;
            deliveryMessage <= memoryCellDataOut;
            r_state         <= ST_DELIVER;
          end
        end

        // Level-held handshake: the receiver's stack push may take any time.
        ST_DELIVER: begin
          r_tick <= 1'b0;
          if (deliveryFinished) begin
            deliveryStart <= 1'b0;
            done          <= 1'b1;
            wakeValid     <= 1'b1;
            wakeProcess   <= r_waiter;
            r_state       <= ST_DONE;
          end else begin
            r_state <= ST_DELIVER;
          end
        end

        ST_DONE: begin
          r_tick       <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
          callerBlocks <= 1'b0;
          wakeValid    <= 1'b0;
          wakeProcess  <= '0;
          error        <= 1'b0;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_tick                  <= 1'b0;
          busy                    <= 1'b0;
          done                    <= 1'b0;
          deliveryStart           <= 1'b0;
          memoryCellReadWriteMode <= RAM_READ;
          r_state                 <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_rendezvous.sv
// Directed bench for channel_rendezvous: RAM model plus a scripted delivery stage.
module tb_channel_rendezvous;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        isSend;
  logic [7:0]  callerProcess;
  logic [15:0] value;
  logic [7:0]  channelAddr;
  logic        busy;
  logic        done;
  logic        callerBlocks;
  logic        wakeValid;
  logic [7:0]  wakeProcess;
  logic        error;
  logic        memoryCellReadWriteMode;
  logic [7:0]  memoryCellAddress;
  logic [15:0] memoryCellDataIn;
  logic [15:0] memoryCellDataOut;
  logic        deliveryStart;
  logic [7:0]  deliveryTarget;
  logic [15:0] deliveryMessage;
  logic        deliveryFinished;

  logic [15:0] mem [256];
  logic        tb_we;
  logic [7:0]  tb_addr;
  logic [15:0] tb_data;

  int n_tests = 0;
  int n_fail  = 0;

  channel_rendezvous #(.addrBits(8), .dataBits(16)) dut (
    .clk(clk), .reset(reset), .start(start), .isSend(isSend),
    .callerProcess(callerProcess), .value(value), .channelAddr(channelAddr),
    .busy(busy), .done(done), .callerBlocks(callerBlocks), .wakeValid(wakeValid),
    .wakeProcess(wakeProcess), .error(error),
    .memoryCellReadWriteMode(memoryCellReadWriteMode),
    .memoryCellAddress(memoryCellAddress), .memoryCellDataIn(memoryCellDataIn),
    .memoryCellDataOut(memoryCellDataOut), .deliveryStart(deliveryStart),
    .deliveryTarget(deliveryTarget), .deliveryMessage(deliveryMessage),
    .deliveryFinished(deliveryFinished)
  );

  always #5 clk = ~clk;

  assign memoryCellDataOut = mem[memoryCellAddress];

  always @(posedge clk) begin
    if (memoryCellReadWriteMode == 1'b1) mem[memoryCellAddress] <= memoryCellDataIn;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issues one op, plays the delivery stage (finishing fin_delay cycles after
  // deliveryStart is first seen) and reports what happened, all in cycles from start.
  task automatic run_op(input logic s, input logic [7:0] p, input logic [15:0] v,
                        input logic [7:0] a, input int fin_delay, input int inject_cyc,
                        output int done_cyc, output int ds_cyc, output logic busy1,
                        output logic [7:0] tgt, output logic [15:0] msg, output logic unstable,
                        output logic cb, output logic wv, output logic er, output logic [7:0] wp);
    int cyc;
    int held;
    done_cyc = -1; ds_cyc = -1; held = 0; tgt = '0; msg = '0; unstable = 1'b0;
    cb = 1'b0; wv = 1'b0; er = 1'b0; wp = '0; busy1 = 1'b0;
    @(negedge clk);
    start = 1'b1; isSend = s; callerProcess = p; value = v; channelAddr = a;
    @(negedge clk);
    start = 1'b0; isSend = ~s; callerProcess = 8'h99; value = 16'h0F0F; channelAddr = 8'h77;
    cyc = 1;
    busy1 = busy;
    while (cyc < 80 && done_cyc < 0) begin
      deliveryFinished = 1'b0;
      if (done) begin
        done_cyc = cyc; cb = callerBlocks; wv = wakeValid; er = error; wp = wakeProcess;
      end else begin
        if (deliveryStart) begin
          if (ds_cyc < 0) begin
            ds_cyc = cyc; tgt = deliveryTarget; msg = deliveryMessage;
          end else begin
            held++;
            if (deliveryTarget !== tgt || deliveryMessage !== msg) unstable = 1'b1;
          end
          if (held == fin_delay) deliveryFinished = 1'b1;
        end
        if (cyc == inject_cyc) begin
          start = 1'b1; isSend = 1'b0; callerProcess = 8'h33; channelAddr = 8'h40;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    deliveryFinished = 1'b0;
  endtask

  int          dc, dsc;
  logic        b1, uns, cb, wv, er;
  logic [7:0]  tg, wp;
  logic [15:0] ms;

  initial begin
    reset = 1'b0; start = 1'b0; isSend = 1'b0; callerProcess = '0; value = '0;
    channelAddr = '0; deliveryFinished = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dstart", deliveryStart, 1'b0);
    chk("rst_mode", memoryCellReadWriteMode, 1'b0);
    chk("rst_addr", memoryCellAddress, 8'h00);
    chk("rst_flags", {callerBlocks, wakeValid, error}, 3'b000);
    reset = 1'b1;
    poke(8'h20, 16'h0000); poke(8'h21, 16'h0000); poke(8'h30, 16'h0000);
    poke(8'h40, 16'h0000); poke(8'hFF, 16'h0000); poke(8'h00, 16'h0000);

    // 1: park on RECEIVE
    run_op(1'b0, 8'h05, 16'h1111, 8'h20, 0, -1, dc, dsc, b1, tg, ms, uns, cb, wv, er, wp);
    chk("t1_busy_c1", b1, 1'b1);
    chk("t1_done_cyc", dc, 5);
    chk("t1_flags", {cb, wv, er}, 3'b100);
    chk("t1_no_deliv", dsc, -1);
    chk("t1_word0", mem[8'h20], 16'h8005);
    chk("t1_word1", mem[8'h21], 16'h0000);
    @(negedge clk);
    chk("t1_idle", {busy, done, callerBlocks}, 3'b000);

    // 2: park on SEND, with a start pulsed while busy
    poke(8'h20, 16'h0000);
    run_op(1'b1, 8'h07, 16'hBEEF, 8'h20, 0, 2, dc, dsc, b1, tg, ms, uns, cb, wv, er, wp);
    chk("t2_done_cyc", dc, 7);
    chk("t2_flags", {cb, wv, er}, 3'b100);
    chk("t2_word0", mem[8'h20], 16'hC007);
    chk("t2_word1", mem[8'h21], 16'hBEEF);
    chk("t2_ignored_start", mem[8'h40], 16'h0000);
    repeat (3) @(negedge clk);
    chk("t2_stays_idle", busy, 1'b0);

    // 3: SEND pairs with a parked receiver
    poke(8'h20, 16'h8005);
    run_op(1'b1, 8'h07, 16'h1234, 8'h20, 6, -1, dc, dsc, b1, tg, ms, uns, cb, wv, er, wp);
    chk("t3_dstart_cyc", dsc, 5);
    chk("t3_target", tg, 8'h05);
    chk("t3_message", ms, 16'h1234);
    chk("t3_stable", uns, 1'b0);
    chk("t3_done_cyc", dc, 12);
    chk("t3_flags", {cb, wv, er}, 3'b010);
    chk("t3_wake", wp, 8'h05);
    chk("t3_word0", mem[8'h20], 16'h0000);
    chk("t3_dstart_low", deliveryStart, 1'b0);

    // 4: RECEIVE pairs with a parked sender
    poke(8'h20, 16'hC007); poke(8'h21, 16'hBEEF);
    run_op(1'b0, 8'h05, 16'h0000, 8'h20, 2, -1, dc, dsc, b1, tg, ms, uns, cb, wv, er, wp);
    chk("t4_dstart_cyc", dsc, 7);
    chk("t4_target", tg, 8'h05);
    chk("t4_message", ms, 16'hBEEF);
    chk("t4_done_cyc", dc, 10);
    chk("t4_flags", {cb, wv, er}, 3'b010);
    chk("t4_wake", wp, 8'h07);
    chk("t4_word0", mem[8'h20], 16'h0000);

    // 5: same-direction waiter is an error
    poke(8'h20, 16'hC007); poke(8'h21, 16'hBEEF);
    run_op(1'b1, 8'h09, 16'h5555, 8'h20, 0, -1, dc, dsc, b1, tg, ms, uns, cb, wv, er, wp);
    chk("t5_done_cyc", dc, 3);
    chk("t5_flags", {cb, wv, er}, 3'b001);
    chk("t5_no_deliv", dsc, -1);
    chk("t5_word0", mem[8'h20], 16'hC007);
    chk("t5_word1", mem[8'h21], 16'hBEEF);

    // 6: record at the top of memory wraps word1 to 0x00
    run_op(1'b1, 8'h11, 16'hA5A5, 8'hFF, 0, -1, dc, dsc, b1, tg, ms, uns, cb, wv, er, wp);
    chk("t6_park_cyc", dc, 7);
    chk("t6_word0", mem[8'hFF], 16'hC011);
    chk("t6_word1_wrap", mem[8'h00], 16'hA5A5);
    run_op(1'b0, 8'h22, 16'h0000, 8'hFF, 1, -1, dc, dsc, b1, tg, ms, uns, cb, wv, er, wp);
    chk("t6_target", tg, 8'h22);
    chk("t6_message", ms, 16'hA5A5);
    chk("t6_wake", wp, 8'h11);
    chk("t6_cleared", mem[8'hFF], 16'h0000);

    // 7: reset during DELIVER, then a fresh op
    poke(8'h20, 16'h8005);
    @(negedge clk);
    start = 1'b1; isSend = 1'b1; callerProcess = 8'h07; value = 16'h4242; channelAddr = 8'h20;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    while (!deliveryStart && dc < 20) begin
      @(negedge clk);
      dc++;
    end
    chk("t7_reached_deliver", deliveryStart, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("t7_rst_outs", {busy, done, deliveryStart, callerBlocks, wakeValid, error}, 6'b000000);
    chk("t7_rst_target", deliveryTarget, 8'h00);
    reset = 1'b1;
    run_op(1'b0, 8'h0A, 16'h0000, 8'h30, 0, -1, dc, dsc, b1, tg, ms, uns, cb, wv, er, wp);
    chk("t7_after_done_cyc", dc, 5);
    chk("t7_after_word0", mem[8'h30], 16'h800A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_rendezvous.md
Name: channel_rendezvous

Overview:
Executes the memory side of a channel SEND or RECEIVE for the running process. Reads the two-word channel record. If no partner is waiting, it parks the caller. If the opposite party is waiting, it pairs them, clears the channel and issues one delivery request to the downstream message-delivery stage, which pushes the value onto the receiver's stack. The block sits between the instruction decoder and the message-delivery stage, sharing the single RAM port through the memory arbiter.

Parameters:
addrBits, 8, RAM address width and process-ID width
dataBits, 16, RAM word width and message width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; op fields below are valid only on this cycle
isSend  in  1  1 = SEND, 0 = RECEIVE
callerProcess  in  addrBits  process ID of the issuing process
value  in  dataBits  value to send (ignored on RECEIVE)
channelAddr  in  addrBits  word address of channel record (record occupies channelAddr, channelAddr+1)
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
callerBlocks  out  1  valid with done; caller must be descheduled
wakeValid  out  1  valid with done; wakeProcess must be made runnable
wakeProcess  out  addrBits  parked partner process to wake
error  out  1  valid with done; same-direction waiter already present
memoryCellReadWriteMode  out  1  RAM_READ / RAM_WRITE
memoryCellAddress  out  addrBits  RAM address
memoryCellDataIn  out  dataBits  RAM write data
memoryCellDataOut  in  dataBits  RAM read data
deliveryStart  out  1  held high until deliveryFinished is seen
deliveryTarget  out  addrBits  receiving process
deliveryMessage  out  dataBits  value to push
deliveryFinished  in  1  downstream completion

Behaviour:
- Reset values: all outputs are 0; the FSM is in IDLE; the tick is 0. Reset mid-operation abandons the op with no further RAM writes; partial channel state is accepted.
- Channel word0 layout: [15] occupied, [14] waiterIsSender, [13:8] zero, [7:0] waiting process ID. Channel word1 holds the parked sender's value.
- Latching: start is accepted only in IDLE. The op fields are latched on that cycle, and busy rises on the next cycle. A start while busy is ignored.
- RAM timing: each RAM access takes 2 cycles.
  - A 1-bit tick alternates each cycle.
  - Address, mode and data are held for both cycles.
  - Read data is sampled on the tick=1 cycle.
  - The FSM advances only on tick=1. The tick is cleared on entry to IDLE.
- Address arithmetic: channelAddr+1 wraps modulo 2^addrBits.
- States:
  - IDLE: waits for start, then goes to READ_HDR.
  - READ_HDR: reads word0. Branches as follows:
    - Not occupied: go to PARK_HDR.
    - Occupied, waiterIsSender != isSend: go to CLEAR_HDR.
    - Occupied, same direction: go to DONE with error=1.
  - PARK_HDR: writes word0 = {1, isSend, 6'b0, callerProcess}. On SEND go to PARK_MSG; otherwise go to DONE with callerBlocks=1.
  - PARK_MSG: writes word1 = value, then goes to DONE with callerBlocks=1.
  - CLEAR_HDR: writes word0 = 0. On SEND go to DELIVER with target=waiter and message=value. On RECEIVE go to READ_MSG.
  - READ_MSG: reads word1, then goes to DELIVER with target=callerProcess and message=word1.
  - DELIVER: no RAM access.
    - deliveryStart is asserted, with target and message stable.
    - On the cycle deliveryFinished=1: drop deliveryStart, go to DONE with wakeValid=1 and wakeProcess=waiter.
    - No timeout.
  - DONE: done=1 for exactly one cycle with the result flags, then return to IDLE with busy=0. The result flags are cleared on return to IDLE.
- Completion latency from start:
  - Park on RECEIVE: 5 cycles.
  - Park on SEND: 7 cycles.
  - Error: 3 cycles.
  - Pairing: RAM cycles + delivery time + 1.
- RAM port when not accessing: address is don't-care; mode is RAM_READ.
- A waiting process ID equal to callerProcess is not special-cased; it is treated per direction.
- error, callerBlocks and wakeValid are mutually exclusive.

Decomposition:
- Shared package / messages.vh constants:
  - channel field positions: CHANNEL_OCCUPIED_BIT=15, CHANNEL_SENDER_BIT=14
  - CHANNEL_MESSAGE_OFFSET=1
  - FSM state encodings (3 bits)
  - RAM_READ / RAM_WRITE (already in defaults.vh)
- Single module.
  - The downstream delivery handshake is a plain level-hold and needs no sub-module.
  - The 2-cycle RAM access tick stays inline.

Test Plan:
1. Empty channel at 0x20, RECEIVE by P=0x05 → word0 becomes 0x8005; done with callerBlocks=1 at cycle 5; no deliveryStart.
2. Empty channel at 0x20, SEND 0xBEEF by P=0x07 → word0=0xC007, word1=0xBEEF; done with callerBlocks=1 at cycle 7.
3. Channel word0=0x8005, SEND 0x1234 by P=0x07 → word0 cleared to 0; deliveryStart with target=0x05, message=0x1234; deliveryFinished after 6 cycles → done with wakeValid=1, wakeProcess=0x05.
4. Channel word0=0xC007, word1=0xBEEF, RECEIVE by P=0x05 → word0=0; delivery with target=0x05, message=0xBEEF; done with wakeProcess=0x07.
5. Channel word0=0xC007, SEND by P=0x09 → done with error=1 at cycle 3; RAM unchanged; no delivery.
6. Other cases:
   - Record at 0xFF: word1 is at 0x00.
   - start pulsed while busy is ignored.
   - reset low during DELIVER → outputs are 0 next cycle; a new start then works.
